// File: rtl/seven_segment_decoder.sv
// Seven-segment pattern decoder with a stability filter and a word assembler.
// A pattern is accepted once it has been seen on STABLE_CYCLES consecutive
// valid samples. Accepted hex digits are shifted into a DIGITS-nibble word
// that is handed off to the consumer with a valid/ready handshake.
module seven_segment_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int DIGITS        = 4
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET_N,
   input  logic [6:0]            SEG_IN,
   input  logic                  SEG_VALID,
   output logic [3:0]            DIGIT,
   output logic                  DIGIT_VALID,
   output logic                  DIGIT_ERR,
   output logic [4*DIGITS-1:0]   WORD,
   output logic                  WORD_VALID,
   input  logic                  WORD_READY,
   output logic                  OVERRUN
);

   // Filter states.
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] COUNT = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   localparam logic [6:0] BLANK      = 7'b1111111;
   localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);
   // Fill value that, once one more digit arrives, completes the word.
   // Comparing against DIGITS-1 keeps a 3-bit counter sufficient for 8 digits.
   localparam logic [2:0] LAST_FILL  = 3'(DIGITS - 1);

   // Returns {is_hex, value}; is_hex is 0 for BLANK and invalid patterns.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'b1000000: r = {1'b1, 4'h0};
         7'b1111001: r = {1'b1, 4'h1};
         7'b0100100: r = {1'b1, 4'h2};
         7'b0110000: r = {1'b1, 4'h3};
         7'b0011001: r = {1'b1, 4'h4};
         7'b0010010: r = {1'b1, 4'h5};
         7'b0000010: r = {1'b1, 4'h6};
         7'b1111000: r = {1'b1, 4'h7};
         7'b0000000: r = {1'b1, 4'h8};
         7'b0010000: r = {1'b1, 4'h9};
         7'b0001000: r = {1'b1, 4'hA};
         7'b0000011: r = {1'b1, 4'hB};
         7'b1000110: r = {1'b1, 4'hC};
         7'b0100001: r = {1'b1, 4'hD};
         7'b0000110: r = {1'b1, 4'hE};
         7'b0001110: r = {1'b1, 4'hF};
         default:    r = 5'b0;
      endcase
      return r;
   endfunction

   // Filter state
   logic [1:0] state_reg, state_next;
   logic [6:0] pat_reg, pat_next;
   logic [7:0] count_reg, count_next;
   logic [7:0] count_inc;
   logic       accept;

   // Output / assembler state
   logic [3:0]          digit_reg, digit_next;
   logic                dv_reg, dv_next;
   logic                err_reg, err_next;
   logic                ovr_reg, ovr_next;
   logic [4*DIGITS-1:0] word_reg, word_next;
   logic [4*DIGITS-1:0] word_shift;
   logic                wv_reg, wv_next;
   logic [2:0]          fill_reg, fill_next;
   logic [2:0]          fill_base;

   logic [4:0] dec;
   logic       is_hex;
   logic       is_blank;
   logic [3:0] hex;
   logic       accept_hex;
   logic       accept_inv;
   logic       handshake;
   logic       pending;

   // The accepted pattern is always the current sample, so decode SEG_IN.
   assign dec        = decode(SEG_IN);
   assign is_hex     = dec[4];
   assign hex        = dec[3:0];
   assign is_blank   = (SEG_IN == BLANK);
   assign accept_hex = accept & is_hex;
   assign accept_inv = accept & ~is_hex & ~is_blank;
   assign count_inc  = count_reg + 8'd1;

   // Word is handed off this cycle / word is stuck waiting for the consumer.
   assign handshake  = wv_reg & WORD_READY;
   assign pending    = wv_reg & ~WORD_READY;

   // New digit enters at the least significant nibble.
   generate
      if (DIGITS == 1) begin : g_single
         assign word_shift = hex;
      end else begin : g_multi
         assign word_shift = {word_reg[4*DIGITS-5:0], hex};
      end
   endgenerate

   // Stability filter: restart on any new pattern, count equal samples, accept once.
   always_comb begin
      state_next = state_reg;
      pat_next   = pat_reg;
      count_next = count_reg;
      accept     = 1'b0;
      if (SEG_VALID) begin
         if (SEG_IN != pat_reg) begin
            pat_next   = SEG_IN;
            count_next = 8'd1;
            if (STABLE_LIM == 8'd1) begin
               accept     = 1'b1;
               state_next = HOLD;
            end else begin
               state_next = COUNT;
            end
         end else if (state_reg == COUNT) begin
            count_next = count_inc;
            if (count_inc == STABLE_LIM) begin
               accept     = 1'b1;
               state_next = HOLD;
            end
         end
      end
   end

   // Assembler: emit digits, build the word, handle handoff and overrun.
   always_comb begin
      digit_next = digit_reg;
      dv_next    = 1'b0;
      err_next   = 1'b0;
      ovr_next   = 1'b0;
      word_next  = word_reg;
      wv_next    = wv_reg;
      fill_next  = fill_reg;
      fill_base  = handshake ? 3'd0 : fill_reg;

      if (handshake) begin
         wv_next   = 1'b0;
         fill_next = 3'd0;
      end

      if (accept_hex) begin
         dv_next    = 1'b1;
         digit_next = hex;
         if (pending) begin
            // Consumer has not taken the finished word: drop this digit.
            ovr_next = 1'b1;
         end else begin
            word_next = word_shift;
            fill_next = fill_base + 3'd1;
            if (fill_base == LAST_FILL) begin
               wv_next = 1'b1;
            end
         end
      end else if (accept_inv) begin
         err_next   = 1'b1;
         digit_next = 4'd0;
         // A finished word still waiting for the consumer is kept intact.
         if (!pending) begin
            word_next = '0;
            fill_next = 3'd0;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg <= IDLE;
         pat_reg   <= BLANK;
         count_reg <= 8'd0;
         digit_reg <= 4'd0;
         dv_reg    <= 1'b0;
         err_reg   <= 1'b0;
         ovr_reg   <= 1'b0;
         word_reg  <= '0;
         wv_reg    <= 1'b0;
         fill_reg  <= 3'd0;
      end else begin
         state_reg <= state_next;
         pat_reg   <= pat_next;
         count_reg <= count_next;
         digit_reg <= digit_next;
         dv_reg    <= dv_next;
         err_reg   <= err_next;
         ovr_reg   <= ovr_next;
         word_reg  <= word_next;
         wv_reg    <= wv_next;
         fill_reg  <= fill_next;
      end
   end

   assign DIGIT       = digit_reg;
   assign DIGIT_VALID = dv_reg;
   assign DIGIT_ERR   = err_reg;
   assign WORD        = word_reg;
   assign WORD_VALID  = wv_reg;
   assign OVERRUN     = ovr_reg;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: directed scenarios plus a randomized run
// checked every cycle against a run-length based reference model.
module tb_seven_segment_decoder;

   localparam int STABLE = 4;
   localparam int NDIG   = 4;

   logic        CLOCK_50 = 1'b0;
   logic        RESET_N  = 1'b0;
   logic [6:0]  SEG_IN   = 7'h7F;
   logic        SEG_VALID = 1'b0;
   logic        WORD_READY = 1'b0;
   logic [3:0]  DIGIT;
   logic        DIGIT_VALID;
   logic        DIGIT_ERR;
   logic [15:0] WORD;
   logic        WORD_VALID;
   logic        OVERRUN;

   seven_segment_decoder #(.STABLE_CYCLES(STABLE), .DIGITS(NDIG)) dut (
      .CLOCK_50   (CLOCK_50),
      .RESET_N    (RESET_N),
      .SEG_IN     (SEG_IN),
      .SEG_VALID  (SEG_VALID),
      .DIGIT      (DIGIT),
      .DIGIT_VALID(DIGIT_VALID),
      .DIGIT_ERR  (DIGIT_ERR),
      .WORD       (WORD),
      .WORD_VALID (WORD_VALID),
      .WORD_READY (WORD_READY),
      .OVERRUN    (OVERRUN)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Segment codes for hex values 0..F, index = value.
   logic [6:0] codes [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   int checks = 0;
   int passed = 0;

   // Pulse observations accumulated by step().
   int         obs_dv, obs_err, obs_ovr;
   logic [3:0] obs_last;

   // Reference model state.
   logic [6:0]  m_last;
   int          m_run;
   logic [3:0]  m_digit;
   logic        m_dv, m_err, m_ovr, m_wv;
   logic [15:0] m_word;
   int          m_fill;

   function automatic int hex_of(input logic [6:0] p);
      for (int i = 0; i < 16; i++) if (codes[i] == p) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_last = 7'h7F; m_run = 0; m_digit = 0;
      m_dv = 0; m_err = 0; m_ovr = 0; m_wv = 0;
      m_word = 0; m_fill = 0;
   endtask

   // A pattern is accepted when its run of valid samples reaches exactly STABLE.
   task automatic model_update(input logic [6:0] seg, input logic valid, input logic ready);
      bit hs;
      bit acc;
      int h;
      hs  = m_wv && ready;
      acc = 0;
      m_dv = 0; m_err = 0; m_ovr = 0;
      if (valid) begin
         if (seg != m_last) begin
            m_last = seg;
            m_run  = 1;
         end else begin
            m_run++;
         end
         acc = (m_run == STABLE);
      end
      if (hs) begin
         m_wv = 0;
         m_fill = 0;
      end
      if (acc && seg != 7'h7F) begin
         h = hex_of(seg);
         if (h >= 0) begin
            m_dv = 1;
            m_digit = 4'(h);
            if (m_wv) m_ovr = 1;
            else begin
               m_word = {m_word[11:0], 4'(h)};
               m_fill++;
               if (m_fill == NDIG) m_wv = 1;
            end
         end else begin
            m_err = 1;
            m_digit = 0;
            if (!m_wv) begin
               m_word = 0;
               m_fill = 0;
            end
         end
      end
   endtask

   task automatic clear_obs();
      obs_dv = 0; obs_err = 0; obs_ovr = 0; obs_last = 4'h0;
   endtask

   // One clock: drive inputs, advance the model, sample outputs 1 time unit after the edge.
   task automatic step(input logic [6:0] seg, input logic valid, input logic ready);
      SEG_IN = seg; SEG_VALID = valid; WORD_READY = ready;
      model_update(seg, valid, ready);
      @(posedge CLOCK_50);
      #1;
      obs_dv  += int'(DIGIT_VALID);
      obs_err += int'(DIGIT_ERR);
      obs_ovr += int'(OVERRUN);
      if (DIGIT_VALID) obs_last = DIGIT;
   endtask

   task automatic hold(input logic [6:0] seg, input int n, input logic ready);
      for (int i = 0; i < n; i++) step(seg, 1'b1, ready);
   endtask

   task automatic do_reset();
      RESET_N = 0; SEG_VALID = 0; WORD_READY = 0; SEG_IN = 7'h7F;
      model_reset();
      repeat (2) @(posedge CLOCK_50);
      #1;
      RESET_N = 1;
   endtask

   task automatic test_reset();
      RESET_N = 0; SEG_VALID = 0; WORD_READY = 0; SEG_IN = 7'h7F;
      model_reset();
      repeat (2) @(posedge CLOCK_50);
      #1;
      checks++;
      if ({DIGIT, DIGIT_VALID, DIGIT_ERR, WORD, WORD_VALID, OVERRUN} !== 25'd0)
         $display("FAIL reset_hold: got %h want 0", {DIGIT, DIGIT_VALID, DIGIT_ERR, WORD, WORD_VALID, OVERRUN});
      else passed++;
      RESET_N = 1;
      step(7'h7F, 1'b1, 1'b0);
      checks++;
      if ({DIGIT, DIGIT_VALID, DIGIT_ERR, WORD, WORD_VALID, OVERRUN} !== 25'd0)
         $display("FAIL reset_release: got %h want 0", {DIGIT, DIGIT_VALID, DIGIT_ERR, WORD, WORD_VALID, OVERRUN});
      else passed++;
   endtask

   task automatic test_stable();
      do_reset();
      clear_obs();
      hold(7'b0110000, 3, 1'b0);
      checks++;
      if (obs_dv !== 0) $display("FAIL stable_early: got %0d pulses want 0", obs_dv);
      else passed++;
      step(7'b0110000, 1'b1, 1'b0);
      checks++;
      if ({DIGIT_VALID, DIGIT} !== {1'b1, 4'h3})
         $display("FAIL stable_accept: got dv=%b digit=%h want dv=1 digit=3", DIGIT_VALID, DIGIT);
      else passed++;
      clear_obs();
      hold(7'b0110000, 10, 1'b0);
      checks++;
      if (obs_dv !== 0) $display("FAIL stable_once: got %0d extra pulses want 0", obs_dv);
      else passed++;
   endtask

   task automatic test_glitch();
      do_reset();
      clear_obs();
      hold(7'b0110000, 3, 1'b0);
      hold(7'b0100100, 1, 1'b0);
      hold(7'b0110000, 6, 1'b0);
      checks++;
      if (obs_dv !== 1 || obs_last !== 4'h3)
         $display("FAIL glitch: got %0d pulses digit=%h want 1 pulse digit=3", obs_dv, obs_last);
      else passed++;
   endtask

   task automatic test_word();
      do_reset();
      for (int d = 1; d <= 4; d++) begin
         hold(codes[d], 4, 1'b0);
         if (d == 4) begin
            checks++;
            if ({WORD_VALID, WORD} !== {1'b1, 16'h1234})
               $display("FAIL word_complete: got wv=%b word=%h want wv=1 word=1234", WORD_VALID, WORD);
            else passed++;
         end
         hold(7'h7F, 1, 1'b0);
      end
      clear_obs();
      hold(codes[10], 4, 1'b0);
      checks++;
      if ({OVERRUN, DIGIT_VALID, DIGIT} !== {1'b1, 1'b1, 4'hA})
         $display("FAIL overrun_pulse: got ovr=%b dv=%b digit=%h want ovr=1 dv=1 digit=a", OVERRUN, DIGIT_VALID, DIGIT);
      else passed++;
      checks++;
      if ({WORD_VALID, WORD} !== {1'b1, 16'h1234} || obs_ovr !== 1)
         $display("FAIL overrun_word: got wv=%b word=%h ovr_pulses=%0d want wv=1 word=1234 pulses=1", WORD_VALID, WORD, obs_ovr);
      else passed++;
   endtask

   // Continues from the pending word left by test_word.
   task automatic test_handshake();
      clear_obs();
      hold(codes[5], 3, 1'b0);
      step(codes[5], 1'b1, 1'b1);
      checks++;
      if ({WORD_VALID, OVERRUN, DIGIT_VALID, WORD} !== {1'b0, 1'b0, 1'b1, 16'h2345})
         $display("FAIL handshake_overlap: got wv=%b ovr=%b dv=%b word=%h want wv=0 ovr=0 dv=1 word=2345",
                  WORD_VALID, OVERRUN, DIGIT_VALID, WORD);
      else passed++;
      for (int d = 6; d <= 8; d++) begin
         hold(7'h7F, 1, 1'b0);
         hold(codes[d], 4, 1'b0);
      end
      checks++;
      if ({WORD_VALID, WORD} !== {1'b1, 16'h5678} || obs_ovr !== 0)
         $display("FAIL handshake_refill: got wv=%b word=%h ovr_pulses=%0d want wv=1 word=5678 pulses=0", WORD_VALID, WORD, obs_ovr);
      else passed++;
      step(7'h7F, 1'b0, 1'b1);
      checks++;
      if ({WORD_VALID, WORD} !== {1'b0, 16'h5678})
         $display("FAIL handshake_plain: got wv=%b word=%h want wv=0 word=5678", WORD_VALID, WORD);
      else passed++;
   endtask

   task automatic test_invalid_gaps();
      logic [6:0] pats [3];
      logic [1:0] want;
      pats[0] = codes[7]; pats[1] = codes[8]; pats[2] = 7'b1010101;
      do_reset();
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 4; i++) begin
            step(pats[d], 1'b1, 1'b0);
            want = (i == 3) ? ((d == 2) ? 2'b01 : 2'b10) : 2'b00;
            checks++;
            if ({DIGIT_VALID, DIGIT_ERR} !== want)
               $display("FAIL gap_timing: pat=%b sample=%0d got dv/err=%b want %b", pats[d], i, {DIGIT_VALID, DIGIT_ERR}, want);
            else passed++;
            if (d == 2 && i == 3) begin
               checks++;
               if ({DIGIT, WORD} !== 20'd0)
                  $display("FAIL invalid_clear: got digit=%h word=%h want 0 0", DIGIT, WORD);
               else passed++;
            end
            step(pats[d], 1'b0, 1'b0);
            checks++;
            if ({DIGIT_VALID, DIGIT_ERR} !== 2'b00)
               $display("FAIL gap_idle: pat=%b got dv/err=%b want 00", pats[d], {DIGIT_VALID, DIGIT_ERR});
            else passed++;
         end
         if (d == 1) begin
            checks++;
            if (WORD !== 16'h0078) $display("FAIL partial_word: got %h want 0078", WORD);
            else passed++;
         end
      end
      hold(codes[9], 4, 1'b0);
      checks++;
      if ({WORD_VALID, WORD} !== {1'b0, 16'h0009})
         $display("FAIL after_invalid: got wv=%b word=%h want wv=0 word=0009", WORD_VALID, WORD);
      else passed++;
   endtask

   task automatic test_reset_midcount();
      do_reset();
      hold(7'b0110000, 4, 1'b0);
      hold(7'b0000000, 2, 1'b0);
      RESET_N = 0;
      model_reset();
      #2;
      checks++;
      if ({DIGIT, DIGIT_VALID, DIGIT_ERR, WORD, WORD_VALID, OVERRUN} !== 25'd0)
         $display("FAIL async_reset: got %h want 0", {DIGIT, DIGIT_VALID, DIGIT_ERR, WORD, WORD_VALID, OVERRUN});
      else passed++;
      @(posedge CLOCK_50);
      #1;
      RESET_N = 1;
      clear_obs();
      hold(7'b0000000, 3, 1'b0);
      checks++;
      if (obs_dv !== 0) $display("FAIL reset_fresh_count: got %0d pulses want 0", obs_dv);
      else passed++;
      step(7'b0000000, 1'b1, 1'b0);
      checks++;
      if ({DIGIT_VALID, DIGIT} !== {1'b1, 4'h8})
         $display("FAIL reset_accept: got dv=%b digit=%h want dv=1 digit=8", DIGIT_VALID, DIGIT);
      else passed++;
   endtask

   task automatic test_random();
      do_reset();
      for (int r = 0; r < 300; r++) begin
         logic [6:0] p;
         int len;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 6) p = codes[$urandom_range(0, 15)];
         else if (sel < 8) p = 7'h7F;
         else p = 7'($urandom);
         len = $urandom_range(1, 8);
         for (int k = 0; k < len; k++) begin
            logic v;
            logic rd;
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) == 0);
            step(p, v, rd);
            checks++;
            if ({DIGIT, DIGIT_VALID, DIGIT_ERR, WORD, WORD_VALID, OVERRUN} !==
                {m_digit, m_dv, m_err, m_word, m_wv, m_ovr})
               $display("FAIL random: seg=%b v=%b rdy=%b got d=%h dv=%b err=%b w=%h wv=%b ovr=%b want d=%h dv=%b err=%b w=%h wv=%b ovr=%b",
                        p, v, rd, DIGIT, DIGIT_VALID, DIGIT_ERR, WORD, WORD_VALID, OVERRUN,
                        m_digit, m_dv, m_err, m_word, m_wv, m_ovr);
            else passed++;
         end
      end
   endtask

   initial begin
      clear_obs();
      model_reset();
      test_reset();
      test_stable();
      test_glitch();
      test_word();
      test_handshake();
      test_invalid_gaps();
      test_reset_midcount();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit, %0d/%0d checks passed so far", passed, checks);
      $fatal(1);
   end

endmodule

// File: doc/seven_segment_decoder.md
SEVEN_SEGMENT_DECODER -- requirements
Module: seven_segment_decoder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- STABLE_CYCLES, 4, number of consecutive identical SEG_VALID samples required to accept a pattern (range 1..255).
- DIGITS, 4, number of digits assembled per word (range 1..8).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLOCK_50, in, 1, the single clock; all logic is rising-edge.
- RESET_N, in, 1, asynchronous active-low reset.
- SEG_IN, in, 7, active-low segment pattern; bit6 = g ... bit0 = a.
- SEG_VALID, in, 1, SEG_IN is sampled this cycle.
- DIGIT, out, 4, decoded hex value.
- DIGIT_VALID, out, 1, one-cycle pulse when a digit is accepted.
- DIGIT_ERR, out, 1, one-cycle pulse when an invalid pattern is accepted.
- WORD, out, 4*DIGITS, assembled digits; the first accepted digit is in the most significant nibble.
- WORD_VALID, out, 1, WORD is complete.
- WORD_READY, in, 1, consumer accepts WORD.
- OVERRUN, out, 1, one-cycle pulse when a digit is dropped.

Function
REQ-003 The decode table SHALL map the following codes, and no others, to hex values:
- 1000000 = 0, 1111001 = 1, 0100100 = 2, 0110000 = 3
- 0011001 = 4, 0010010 = 5, 0000010 = 6, 1111000 = 7
- 0000000 = 8, 0010000 = 9, 0001000 = A, 0000011 = B
- 1000110 = C, 0100001 = D, 0000110 = E, 0001110 = F

REQ-004 Pattern 1111111 SHALL be treated as BLANK: it is never emitted and it re-arms the filter.

REQ-005 Every pattern other than the 16 codes and BLANK SHALL be INVALID.

REQ-006 The filter FSM SHALL have three states: IDLE, COUNT and HOLD.

REQ-007 On a SEG_VALID sample differing from the last stored pattern, the filter SHALL store the pattern, set count = 1 and enter COUNT; if STABLE_CYCLES = 1, it SHALL accept the pattern immediately.

REQ-008 In COUNT, each SEG_VALID sample equal to the stored pattern SHALL increment count; when count reaches STABLE_CYCLES the pattern SHALL be accepted and the FSM SHALL enter HOLD.

REQ-009 In HOLD, equal samples SHALL be ignored, so a stable pattern is accepted exactly once; a differing sample SHALL restart per REQ-007.

REQ-010 Cycles with SEG_VALID = 0 SHALL neither advance nor clear count.

REQ-011 Acceptance of a hex code SHALL drive DIGIT and pulse DIGIT_VALID on the clock edge after the accepting sample (latency 1).

REQ-012 Acceptance of INVALID SHALL pulse DIGIT_ERR, drive DIGIT = 0 and discard the partially filled word.

REQ-013 Acceptance of BLANK SHALL produce no output pulse and no change to the word.

REQ-014 The assembler SHALL shift each accepted digit in as WORD = {WORD[4*DIGITS-5:0], DIGIT}; a 3-bit fill count tracks the digits held.

REQ-015 WORD_VALID SHALL assert in the same cycle as DIGIT_VALID for the DIGITS-th digit and SHALL remain high with WORD frozen until a cycle with WORD_READY = 1.

REQ-016 In the handshake cycle (WORD_VALID = 1 and WORD_READY = 1), WORD_VALID SHALL deassert on the next edge and the fill count SHALL return to 0; WORD retains its value.

REQ-017 If a digit is accepted while WORD_VALID = 1 and WORD_READY = 0, the digit SHALL be dropped, OVERRUN SHALL pulse and DIGIT_VALID SHALL still pulse.

REQ-018 If a digit is accepted in the handshake cycle itself, it SHALL become the first digit of the next word, and no OVERRUN SHALL occur.

REQ-019 An INVALID pattern accepted while WORD_VALID = 1 SHALL pulse DIGIT_ERR only; the pending word SHALL be preserved.

Reset
REQ-020 While RESET_N = 0, the following SHALL be 0:
- DIGIT, DIGIT_VALID, DIGIT_ERR, WORD, WORD_VALID, OVERRUN
- the internal count and fill count

REQ-021 While RESET_N = 0, the FSM SHALL be in IDLE and the stored pattern SHALL be 1111111.

REQ-022 An assertion of RESET_N mid-count or mid-word SHALL abandon all partial state; the first sample after release SHALL be handled as in REQ-007.

Verification
REQ-023 The bench SHALL cover the following directed scenarios (stimulus -> required response, STABLE_CYCLES = 4, DIGITS = 4):
- Stable pattern: 0110000 held for 4 valid samples -> DIGIT = 3 with a single DIGIT_VALID pulse one cycle after the 4th sample; 10 further identical samples -> no further pulse.
- Glitch: 0110000 for 3 samples, then 0100100 for 1 sample, then 0110000 for 4 samples -> exactly one pulse, with DIGIT = 3.
- Word assembly: digits 1, 2, 3, 4, each separated by BLANK -> WORD = 16'h1234 and WORD_VALID = 1; holding WORD_READY = 0 and then accepting digit A -> OVERRUN pulse and WORD still 16'h1234.
- Handshake overlap: digit 5 accepted in the same cycle as WORD_READY = 1 -> WORD_VALID drops on the next edge, no OVERRUN, and fill count = 1.
- Invalid and gaps: 1010101 held for 4 samples after digits 7, 8 -> DIGIT_ERR pulse and the partial word cleared; SEG_VALID gaps inserted between samples -> acceptance timing unchanged.
- Reset mid-count: RESET_N pulsed low after the 2nd sample of 0000000 -> all outputs 0; the same pattern then needs 4 fresh samples to be accepted as DIGIT = 8.
